// File: rtl/dap_swj_seq_ctrl_pkg.sv
// Shared constants and helpers for the SWJ sequence controller.
package dap_swj_seq_ctrl_pkg;

    // Engine opcode for a raw SWJ bit sequence (cmd[15:12]).
    localparam logic [3:0] SEQ_CMD_SWJ_SEQ = 4'h2;
    // Engine data width: maximum bits carried by one tx FIFO entry.
    localparam int SEQ_CHUNK_BITS = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PUSH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Bits in the next chunk: min(64, remaining).
    function automatic logic [6:0] chunk_of(input logic [8:0] remaining);
        return (remaining >= 9'd64) ? 7'd64 : remaining[6:0];
    endfunction

    // Bytes needed to carry a chunk: ceil(chunk/8), 1..8.
    function automatic logic [3:0] nbytes_of(input logic [6:0] chunk);
        logic [7:0] w_sum;
        w_sum = {1'b0, chunk} + 8'd7;
        return w_sum[6:3];
    endfunction

    function automatic logic [15:0] swj_cmd(input logic [6:0] chunk);
        return {SEQ_CMD_SWJ_SEQ, 4'h0, 1'b0, chunk};
    endfunction

endpackage

// File: rtl/dap_swj_seq_ctrl_rx_drain.sv
// Response side: pops the engine rx FIFO, tracks chunks in flight, merges flags.
module dap_seq_rx_drain
    import dap_swj_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_en,
    input  logic        i_tx_strobe,
    input  logic        i_err_clr,
    input  logic        i_rx_valid,
    input  logic [15:0] i_rx_flag,
    output logic        o_rx_nxt,
    output logic [2:0]  o_outstanding,
    output logic        o_err
);

    logic       r_rx_hold;
    logic [2:0] r_outstanding;
    logic       r_err;
    logic       w_rx_nxt;

    // The FIFO empty flag lags the read strobe by a cycle, so every strobe
    // is followed by one blanked cycle.
    assign w_rx_nxt = i_en && i_rx_valid && !r_rx_hold;

    // Hold, in-flight count (saturating at 0) and sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_hold     <= 1'b0;
            r_outstanding <= 3'd0;
            r_err         <= 1'b0;
        end else begin
            r_rx_hold <= w_rx_nxt;
            if (i_tx_strobe && !w_rx_nxt)
                r_outstanding <= r_outstanding + 3'd1;
            else if (!i_tx_strobe && w_rx_nxt && (r_outstanding != 3'd0))
                r_outstanding <= r_outstanding - 3'd1;
            r_err <= (r_err && !i_err_clr) || (w_rx_nxt && (i_rx_flag != 16'd0));
        end
    end

    assign o_rx_nxt      = w_rx_nxt;
    assign o_outstanding = r_outstanding;
    assign o_err         = r_err;

endmodule

// File: rtl/dap_swj_seq_ctrl.sv
// Executes one DAP_SWJ_Sequence request: packs bytes into <=64-bit chunks,
// writes them to the sequence engine and waits for every response.
//
// state | meaning
// IDLE  | waiting for a request
// LOAD  | collecting the bytes of the current chunk
// PUSH  | chunk ready, strobing it into the engine tx FIFO
// DRAIN | all chunks sent, waiting for outstanding responses
// DONE  | one-cycle completion pulse
module dap_swj_seq_ctrl
    import dap_swj_seq_ctrl_pkg::*;
#(
    parameter int CHUNK_BITS = SEQ_CHUNK_BITS
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_count,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [7:0]            data_byte,
    output logic                  done_valid,
    output logic                  done_status,
    output logic                  seq_tx_valid,
    output logic [15:0]           seq_tx_cmd,
    output logic [CHUNK_BITS-1:0] seq_tx_data,
    input  logic                  seq_tx_full,
    input  logic                  seq_rx_valid,
    output logic                  seq_rx_nxt,
    input  logic [15:0]           seq_rx_flag,
    input  logic [CHUNK_BITS-1:0] seq_rx_data
);

    seq_state_t            r_state, w_state_nxt;
    logic                  r_run;
    logic [8:0]            r_remaining;
    logic [3:0]            r_byte_idx;
    logic [15:0]           r_tx_cmd;
    logic [CHUNK_BITS-1:0] r_tx_data;

    logic [6:0] w_chunk;
    logic [3:0] w_nbytes;
    logic [8:0] w_rem_after;
    logic       w_accept, w_byte_take, w_last_byte;
    logic       w_req_ready, w_data_ready, w_tx_valid, w_done;
    logic [2:0] w_outstanding;
    logic       w_err;
    logic       w_unused_rx;

    assign w_chunk     = chunk_of(r_remaining);
    assign w_nbytes    = nbytes_of(w_chunk);
    assign w_rem_after = r_remaining - {2'b00, w_chunk};
    assign w_accept    = w_req_ready && req_valid;
    assign w_byte_take = w_data_ready && data_valid;
    assign w_last_byte = (r_byte_idx == (w_nbytes - 4'd1));
    assign w_unused_rx = ^seq_rx_data;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_ready  = 1'b0;
        w_data_ready = 1'b0;
        w_tx_valid   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = r_run;
                if (r_run && req_valid) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_data_ready = 1'b1;
                if (data_valid && w_last_byte) w_state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                if (!seq_tx_full) begin
                    w_tx_valid  = 1'b1;
                    w_state_nxt = (w_rem_after != 9'd0) ? ST_LOAD : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_outstanding == 3'd0) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request length, byte packing and registered engine command.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_run       <= 1'b0;
            r_remaining <= 9'd0;
            r_byte_idx  <= 4'd0;
            r_tx_cmd    <= 16'd0;
            r_tx_data   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_remaining <= (req_count == 8'd0) ? 9'd256 : {1'b0, req_count};
                r_byte_idx  <= 4'd0;
                r_tx_data   <= '0;
            end
            if (w_byte_take) begin
                r_tx_data[{r_byte_idx[2:0], 3'b000} +: 8] <= data_byte;
                r_byte_idx <= r_byte_idx + 4'd1;
                if (w_last_byte) r_tx_cmd <= swj_cmd(w_chunk);
            end
            if (w_tx_valid) begin
                r_remaining <= w_rem_after;
                r_byte_idx  <= 4'd0;
                r_tx_data   <= '0;
            end
        end
    end

    dap_seq_rx_drain u_rx_drain (
        .clk           (clk),
        .resetn        (resetn),
        .i_en          (r_run),
        .i_tx_strobe   (w_tx_valid),
        .i_err_clr     (w_accept),
        .i_rx_valid    (seq_rx_valid),
        .i_rx_flag     (seq_rx_flag),
        .o_rx_nxt      (seq_rx_nxt),
        .o_outstanding (w_outstanding),
        .o_err         (w_err)
    );

    assign req_ready    = w_req_ready;
    assign data_ready   = w_data_ready;
    assign seq_tx_valid = w_tx_valid;
    assign seq_tx_cmd   = r_tx_cmd;
    assign seq_tx_data  = r_tx_data;
    assign done_valid   = w_done;
    assign done_status  = w_done && w_err;

endmodule

// File: tb/tb_dap_swj_seq_ctrl.sv
// Directed bench for the SWJ sequence controller with a small engine model.
module tb_dap_swj_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [7:0]  req_count;
    logic        data_valid, data_ready;
    logic [7:0]  data_byte;
    logic        done_valid, done_status;
    logic        seq_tx_valid;
    logic [15:0] seq_tx_cmd;
    logic [63:0] seq_tx_data;
    logic        seq_tx_full;
    logic        seq_rx_valid, seq_rx_nxt;
    logic [15:0] seq_rx_flag;
    logic [63:0] seq_rx_data;

    localparam logic [3:0] EXP_OPC = 4'h2;

    dap_swj_seq_ctrl #(.CHUNK_BITS(64)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_count(req_count),
        .data_valid(data_valid), .data_ready(data_ready), .data_byte(data_byte),
        .done_valid(done_valid), .done_status(done_status),
        .seq_tx_valid(seq_tx_valid), .seq_tx_cmd(seq_tx_cmd), .seq_tx_data(seq_tx_data),
        .seq_tx_full(seq_tx_full),
        .seq_rx_valid(seq_rx_valid), .seq_rx_nxt(seq_rx_nxt),
        .seq_rx_flag(seq_rx_flag), .seq_rx_data(seq_rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [15:0] cap_cmd[$];
    logic [63:0] cap_data[$];
    int          cap_cyc[$];
    logic [15:0] flag_q[$];
    logic [15:0] pend[$];
    int          nxt_cnt, done_cnt, done_nxt;
    logic        done_st;
    logic [7:0]  tb_bytes[64];
    int          last_hs_cyc, first_wait;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Engine model: captures tx strobes, returns one response per strobe.
    initial begin : engine
        logic do_pop, do_push;
        logic [15:0] f;
        seq_rx_valid = 1'b0;
        seq_rx_flag  = 16'd0;
        seq_rx_data  = 64'd0;
        forever begin
            @(negedge clk);
            do_pop  = seq_rx_nxt && seq_rx_valid;
            do_push = seq_tx_valid;
            if (seq_rx_nxt) nxt_cnt++;
            if (seq_tx_valid) begin
                cap_cmd.push_back(seq_tx_cmd);
                cap_data.push_back(seq_tx_data);
                cap_cyc.push_back(cyc);
            end
            if (done_valid) begin
                done_cnt++;
                done_st  = done_status;
                done_nxt = nxt_cnt;
            end
            @(posedge clk);
            #1;
            if (!resetn) pend.delete();
            else begin
                if (do_pop && pend.size() > 0) void'(pend.pop_front());
                if (do_push) begin
                    f = (flag_q.size() > 0) ? flag_q.pop_front() : 16'd0;
                    pend.push_back(f);
                end
            end
            seq_rx_valid = (pend.size() > 0);
            seq_rx_flag  = (pend.size() > 0) ? pend[0] : 16'd0;
        end
    end

    task automatic clear_caps();
        cap_cmd.delete(); cap_data.delete(); cap_cyc.delete(); flag_q.delete();
        nxt_cnt = 0; done_cnt = 0; done_nxt = 0; done_st = 1'b0;
    endtask

    task automatic do_req(input logic [7:0] cnt);
        int n;
        logic acc;
        n = 0;
        req_valid = 1'b1;
        req_count = cnt;
        do begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 50);
        req_valid = 1'b0;
        if (!acc) chk("req_timeout", 0, 1);
    endtask

    task automatic send_bytes(input int first, input int nb);
        int n;
        logic acc;
        for (int i = 0; i < nb; i++) begin
            n = 0;
            data_valid = 1'b1;
            data_byte  = tb_bytes[first + i];
            do begin
                @(negedge clk); acc = data_ready;
                if (acc) last_hs_cyc = cyc;
                @(posedge clk); #1; n++;
            end while (!acc && n < 50);
            if (i == 0) first_wait = n;
            if (!acc) begin
                chk("byte_timeout", 0, 1);
                break;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("done_timeout", (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack8(input int first, input int nb);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = tb_bytes[first + i];
        return v;
    endfunction

    function automatic logic [15:0] ecmd(input logic [7:0] bits);
        return {EXP_OPC, 4'h0, bits};
    endfunction

    initial begin
        int drop_cyc, unstable;
        resetn = 1'b0; req_valid = 1'b0; req_count = 8'd0;
        data_valid = 1'b0; data_byte = 8'd0; seq_tx_full = 1'b0;
        clear_caps();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {req_ready, data_ready, done_valid, done_status, seq_tx_valid, seq_rx_nxt}, 0);
        chk("rst_cmd", seq_tx_cmd, 0);
        chk("rst_data", seq_tx_data, 0);
        @(posedge clk); #1; resetn = 1'b1;
        @(negedge clk);
        chk("ready_pre", req_ready, 0);
        @(negedge clk);
        chk("ready_rise", req_ready, 1);
        @(posedge clk); #1;

        // Single 8-bit chunk
        clear_caps();
        tb_bytes[0] = 8'hA5;
        flag_q.push_back(16'd0);
        do_req(8'd8);
        send_bytes(0, 1);
        wait_done();
        chk("t1_acc_to_data", first_wait, 1);
        chk("t1_strobes", cap_cmd.size(), 1);
        if (cap_cmd.size() == 1) begin
            chk("t1_cmd", cap_cmd[0], ecmd(8'd8));
            chk("t1_data", cap_data[0], 64'hA5);
            chk("t1_lat", cap_cyc[0] - last_hs_cyc, 1);
        end
        chk("t1_status", done_st, 0);
        chk("t1_done_cnt", done_cnt, 1);

        // 256 bits as four 64-bit chunks
        clear_caps();
        for (int i = 0; i < 32; i++) tb_bytes[i] = 8'(i);
        do_req(8'd0);
        send_bytes(0, 32);
        wait_done();
        chk("t2_strobes", cap_cmd.size(), 4);
        if (cap_cmd.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_cmd", cap_cmd[i], ecmd(8'd64));
            chk("t2_data0", cap_data[0], 64'h0706050403020100);
            chk("t2_data3", cap_data[3], 64'h1F1E1D1C1B1A1918);
        end
        chk("t2_nxt_at_done", done_nxt, 4);
        chk("t2_status", done_st, 0);

        // 70 bits: 64 + 6, short byte keeps its upper bits
        clear_caps();
        for (int i = 0; i < 9; i++) tb_bytes[i] = 8'h10 + 8'(i);
        tb_bytes[8] = 8'hF8;
        do_req(8'd70);
        send_bytes(0, 9);
        wait_done();
        chk("t3_strobes", cap_cmd.size(), 2);
        if (cap_cmd.size() == 2) begin
            chk("t3_cmd0", cap_cmd[0], ecmd(8'd64));
            chk("t3_data0", cap_data[0], 64'h1716151413121110);
            chk("t3_cmd1", cap_cmd[1], ecmd(8'd6));
            chk("t3_data1", cap_data[1], 64'hF8);
        end
        chk("t3_status", done_st, 0);

        // tx FIFO full holds the chunk in PUSH
        clear_caps();
        tb_bytes[0] = 8'h3C;
        seq_tx_full = 1'b1;
        do_req(8'd8);
        send_bytes(0, 1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (seq_tx_valid || seq_tx_cmd !== ecmd(8'd8) || seq_tx_data !== 64'h3C) unstable++;
            @(posedge clk); #1;
        end
        chk("t4_held_unstable", unstable, 0);
        chk("t4_no_strobe", cap_cmd.size(), 0);
        seq_tx_full = 1'b0;
        drop_cyc = cyc;
        wait_done();
        chk("t4_strobes", cap_cmd.size(), 1);
        if (cap_cmd.size() == 1) begin
            chk("t4_release_lat", cap_cyc[0] - drop_cyc, 0);
            chk("t4_data", cap_data[0], 64'h3C);
        end

        // Nonzero flag on second response, then a clean request
        clear_caps();
        for (int i = 0; i < 16; i++) tb_bytes[i] = 8'h80 + 8'(i);
        flag_q.push_back(16'h0000);
        flag_q.push_back(16'h0001);
        do_req(8'd128);
        send_bytes(0, 16);
        wait_done();
        chk("t5_status_err", done_st, 1);
        clear_caps();
        tb_bytes[0] = 8'h5A;
        do_req(8'd8);
        send_bytes(0, 1);
        wait_done();
        chk("t5_status_ok", done_st, 0);

        // Reset in the middle of loading
        clear_caps();
        for (int i = 0; i < 9; i++) tb_bytes[i] = 8'hC0 + 8'(i);
        do_req(8'd72);
        send_bytes(0, 3);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_ctrl", {req_ready, data_ready, done_valid, done_status, seq_tx_valid, seq_rx_nxt}, 0);
        chk("t6_rst_cmd", seq_tx_cmd, 0);
        chk("t6_rst_data", seq_tx_data, 0);
        repeat (3) @(posedge clk);
        #1; resetn = 1'b1;
        chk("t6_no_strobe", cap_cmd.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        clear_caps();
        tb_bytes[0] = 8'h81;
        do_req(8'd8);
        send_bytes(0, 1);
        wait_done();
        chk("t6_strobes", cap_cmd.size(), 1);
        if (cap_cmd.size() == 1) chk("t6_data", cap_data[0], 64'h81);
        chk("t6_status", done_st, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
